// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, NDIG = WIDTH/DIGIT RUN cycles.
// Define SERIAL_ADD_SUB_SATURATE_EN to clamp S to the signed limit on overflow.
module serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             AddLSubH,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V,
  output logic             Z,
  output logic             N,
  output logic [1:0]       dbg_state_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opy_q, opy_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              amsb_q, amsb_d;
  logic              ymsb_q, ymsb_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d;

  logic [DIGIT:0]    dsum;
  logic [WIDTH-1:0]  d_ext;
  logic [WIDTH-1:0]  res_shift;
  logic [WIDTH-1:0]  s_fin;
  logic              raw_v;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and S/flags hold until consumed.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign S           = s_q;
  assign Co          = co_q;
  assign V           = v_q;
  assign Z           = z_q;
  assign N           = n_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opy_d   = opy_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    ymsb_d  = ymsb_q;
    s_d     = s_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;

    dsum  = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opy_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    d_ext = '0;
    d_ext[DIGIT-1:0] = dsum[DIGIT-1:0];
    // New digit enters at the top so the LSB digit ends up at the bottom after NDIG shifts.
    res_shift = (res_q >> DIGIT) | (d_ext << (WIDTH - DIGIT));
    raw_v     = (amsb_q == ymsb_q) & (res_shift[WIDTH-1] != amsb_q);
`ifdef SERIAL_ADD_SUB_SATURATE_EN
    s_fin = raw_v ? {amsb_q, {(WIDTH-1){~amsb_q}}} : res_shift;
`else
    s_fin = res_shift;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = A;
          opy_d   = AddLSubH ? ~B : B;
          carry_d = AddLSubH;
          amsb_d  = A[WIDTH-1];
          ymsb_d  = AddLSubH ? ~B[WIDTH-1] : B[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> DIGIT;
        opy_d   = opy_q >> DIGIT;
        res_d   = res_shift;
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = s_fin;
          co_d    = dsum[DIGIT];
          v_d     = raw_v;
          z_d     = (s_fin == '0);
          n_d     = s_fin[WIDTH-1];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opy_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      amsb_q  <= 1'b0;
      ymsb_q  <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opy_q   <= opy_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      ymsb_q  <= ymsb_d;
      s_q     <= s_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub; runs DIGIT=4, DIGIT=1 and DIGIT=16 instances side by side on shared inputs.
module tb_serial_add_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         add_l_sub_h = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         ir [3];
  logic         ov [3];
  logic         co [3];
  logic         v  [3];
  logic         z  [3];
  logic         n  [3];
  logic [W-1:0] s  [3];
  logic [1:0]   st [3];

  int total = 0;
  int bad = 0;
  int lat [3];
  int exp_lat [3] = '{4, 16, 1};
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         v;
    logic         z;
    logic         n;
  } vec_t;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(W), .DIGIT(4)) u_dig4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .A(a), .B(b),
    .AddLSubH(add_l_sub_h), .out_valid(ov[0]), .out_ready(out_ready), .S(s[0]),
    .Co(co[0]), .V(v[0]), .Z(z[0]), .N(n[0]), .dbg_state_o(st[0])
  );

  serial_add_sub #(.WIDTH(W), .DIGIT(1)) u_dig1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .A(a), .B(b),
    .AddLSubH(add_l_sub_h), .out_valid(ov[1]), .out_ready(out_ready), .S(s[1]),
    .Co(co[1]), .V(v[1]), .Z(z[1]), .N(n[1]), .dbg_state_o(st[1])
  );

  serial_add_sub #(.WIDTH(W), .DIGIT(16)) u_dig16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .A(a), .B(b),
    .AddLSubH(add_l_sub_h), .out_valid(ov[2]), .out_ready(out_ready), .S(s[2]),
    .Co(co[2]), .V(v[2]), .Z(z[2]), .N(n[2]), .dbg_state_o(st[2])
  );

  // Presents one operation, scrambles the inputs after acceptance, and records
  // the number of clocks until each instance raises out_valid (-1 = never).
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic sub);
    @(negedge clk);
    a = op_a; b = op_b; add_l_sub_h = sub; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom_range(0, 16'hFFFF));
    b = 16'($urandom_range(0, 16'hFFFF));
    add_l_sub_h = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) lat[i] = ov[i] ? 0 : -1;
    for (int c = 1; c <= 40; c++) begin
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (lat[i] < 0 && ov[i]) lat[i] = c;
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || s[i] !== 16'h0000 || st[i] !== 2'd0 ||
          {co[i], v[i], z[i], n[i]} !== 4'b0000) begin
        bad++;
        $display("FAIL reset dut%0d: got ir=%b ov=%b S=%h st=%0d CoVZN=%b%b%b%b want ir=1 ov=0 S=0000 st=0 CoVZN=0000",
                 i, ir[i], ov[i], s[i], st[i], co[i], v[i], z[i], n[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    vec_t vecs [5];
    logic [W-1:0] exp_s;
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef SERIAL_ADD_SUB_SATURATE_EN
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(vecs[k].s);
      run_op(vecs[k].a, vecs[k].b, vecs[k].sub);
      exp_s = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (lat[i] != exp_lat[i]) begin
          bad++;
          $display("FAIL arith%0d dut%0d latency: got %0d want %0d", k, i, lat[i], exp_lat[i]);
        end
        total++;
        if (s[i] !== exp_s) begin
          bad++;
          $display("FAIL arith%0d dut%0d S: got %h want %h", k, i, s[i], exp_s);
        end
        total++;
        if ({co[i], v[i], z[i], n[i]} !== {vecs[k].co, vecs[k].v, vecs[k].z, vecs[k].n}) begin
          bad++;
          $display("FAIL arith%0d dut%0d CoVZN: got %b%b%b%b want %b%b%b%b", k, i,
                   co[i], v[i], z[i], n[i], vecs[k].co, vecs[k].v, vecs[k].z, vecs[k].n);
        end
      end
      release_op();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (ir[i] !== 1'b1 || ov[i] !== 1'b0) begin
          bad++;
          $display("FAIL arith%0d dut%0d release: got ir=%b ov=%b want ir=1 ov=0", k, i, ir[i], ov[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; add_l_sub_h = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || s[i] !== 16'h0000 || st[i] !== 2'd0 ||
          {co[i], v[i], z[i], n[i]} !== 4'b0000) begin
        bad++;
        $display("FAIL midreset dut%0d: got ir=%b ov=%b S=%h st=%0d CoVZN=%b%b%b%b want ir=1 ov=0 S=0000 st=0 CoVZN=0000",
                 i, ir[i], ov[i], s[i], st[i], co[i], v[i], z[i], n[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h1234, 16'h0FFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (lat[i] != exp_lat[i] || s[i] !== 16'h2233 || {co[i], v[i], z[i], n[i]} !== 4'b0000) begin
        bad++;
        $display("FAIL rerun dut%0d: got lat=%0d S=%h CoVZN=%b%b%b%b want lat=%0d S=2233 CoVZN=0000",
                 i, lat[i], s[i], co[i], v[i], z[i], n[i], exp_lat[i]);
      end
    end
    release_op();
  endtask

  task automatic test_hold();
    run_op(16'h1234, 16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (lat[i] != exp_lat[i]) begin
        bad++;
        $display("FAIL hold dut%0d latency: got %0d want %0d", i, lat[i], exp_lat[i]);
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (ov[i] !== 1'b1 || ir[i] !== 1'b0 || s[i] !== 16'h0000 || st[i] !== 2'd2 ||
            {co[i], v[i], z[i], n[i]} !== 4'b1010) begin
          bad++;
          $display("FAIL hold%0d dut%0d: got ov=%b ir=%b S=%h st=%0d CoVZN=%b%b%b%b want ov=1 ir=0 S=0000 st=2 CoVZN=1010",
                   k, i, ov[i], ir[i], s[i], st[i], co[i], v[i], z[i], n[i]);
        end
      end
      a = 16'($urandom_range(1, 16'hFFFF));
      b = 16'($urandom_range(0, 16'hFFFF));
      add_l_sub_h = 1'($urandom_range(0, 1));
      in_valid = (k % 2 == 0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_op();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || st[i] !== 2'd0 || s[i] !== 16'h0000 || z[i] !== 1'b1) begin
        bad++;
        $display("FAIL hold_release dut%0d: got ir=%b ov=%b st=%0d S=%h Z=%b want ir=1 ov=0 st=0 S=0000 Z=1",
                 i, ir[i], ov[i], st[i], s[i], z[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_reset_mid_run();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
